// File: rtl/vga_text_pkg.sv
// Shared text-mode geometry and attribute-word layout for the text pixel pipeline.
// The attribute byte sits above the character code in each text RAM word.
package vga_text_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  localparam int CHAR_LSB   = 0;
  localparam int ATTR_FG    = 8;
  localparam int ATTR_BG    = 12;
  localparam int ATTR_BLINK = 15;

  typedef struct packed {
    logic       blink;
    logic [2:0] bg;
    logic [3:0] fg;
  } attr_t;

  function automatic attr_t unpack_attr(input logic [15:0] word);
    attr_t a;
    a.fg    = word[ATTR_FG +: 4];
    a.bg    = word[ATTR_BG +: 3];
    a.blink = word[ATTR_BLINK];
    return a;
  endfunction

  // Background colours only reach the lower half of the palette.
  function automatic logic [3:0] pal_index(input logic on, input attr_t a);
    return on ? a.fg : {1'b0, a.bg};
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Counts vsync assertions to derive the text blink phase.
// Edge is taken against the registered vsync so the count moves on the asserting sample.
module blink_timer #(
  parameter logic SYNC_POL  = 1'b0,
  parameter int   BLINK_LOG = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync_in,
  output logic phase
);

  logic                 w_vs_act;
  logic                 r_vs_act;
  logic [BLINK_LOG-1:0] r_frame_cnt;

  assign w_vs_act = (vsync_in == SYNC_POL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_act    <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vs_act <= w_vs_act;
      if (w_vs_act && !r_vs_act)
        r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign phase = r_frame_cnt[BLINK_LOG-1];

endmodule

// File: rtl/text_pixel_pipe.sv
// Four-stage text-mode pixel generator: text RAM -> font ROM -> palette index,
// with syncs and active carried alongside so every output lines up with its pixel.
module text_pixel_pipe #(
  parameter int   COLS      = vga_text_pkg::COLS,
  parameter int   ROWS      = vga_text_pkg::ROWS,
  parameter int   CHAR_W    = vga_text_pkg::CHAR_W,
  parameter int   CHAR_H    = vga_text_pkg::CHAR_H,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   BLINK_LOG = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  output logic [11:0] tram_addr,
  input  logic [15:0] tram_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  fg,
  output logic [3:0]  bg,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out
);

  import vga_text_pkg::attr_t;
  import vga_text_pkg::unpack_attr;
  import vga_text_pkg::pal_index;
  import vga_text_pkg::CHAR_LSB;

  localparam int         COL_SH    = $clog2(CHAR_W);
  localparam int         ROW_SH    = $clog2(CHAR_H);
  localparam logic [3:0] GR_MASK   = 4'(CHAR_H - 1);
  localparam logic [3:0] CUR_GR    = 4'(CHAR_H - 2);
  localparam logic [9:0] VIS_W     = 10'(COLS * CHAR_W);
  localparam logic [9:0] VIS_H     = 10'(ROWS * CHAR_H);
  localparam logic [11:0] COLS_W   = 12'(COLS);
  localparam logic       SYNC_IDLE = ~SYNC_POL;

  // Stage-1 address and pixel decode
  logic [9:0]  w_col;
  logic [9:0]  w_row;
  logic [11:0] w_addr;
  logic [3:0]  w_gr;
  logic        w_hit;
  logic        w_vis;
  logic        w_phase;

  assign w_col  = x >> COL_SH;
  assign w_row  = y >> ROW_SH;
  assign w_addr = 12'(w_row) * COLS_W + 12'(w_col);
  assign w_gr   = y[3:0] & GR_MASK;
  assign w_vis  = active_in && (x < VIS_W) && (y < VIS_H);
  assign w_hit  = cursor_en && (w_col == {3'b000, cursor_col}) &&
                  (w_row == {5'b00000, cursor_row}) && (w_gr >= CUR_GR);

  blink_timer #(
    .SYNC_POL  (SYNC_POL),
    .BLINK_LOG (BLINK_LOG)
  ) u_blink (
    .clk      (clk),
    .rst      (rst),
    .vsync_in (vsync_in),
    .phase    (w_phase)
  );

  logic [11:0] r_tram_addr;
  logic [2:0]  r1_px, r2_px, r3_px;
  logic [3:0]  r1_gr, r2_gr;
  logic        r1_act, r2_act, r3_act;
  logic        r1_vis, r2_vis, r3_vis;
  logic        r1_hs, r2_hs, r3_hs;
  logic        r1_vs, r2_vs, r3_vs;
  logic        r1_hit, r2_hit, r3_hit;
  logic        r1_phase, r2_phase, r3_phase;
  logic        r1_run, r2_run;
  attr_t       r3_attr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tram_addr <= '0;
      r1_px <= '0; r1_gr <= '0; r1_act <= 1'b0; r1_vis <= 1'b0;
      r1_hs <= SYNC_IDLE; r1_vs <= SYNC_IDLE; r1_hit <= 1'b0; r1_phase <= 1'b0;
      r1_run <= 1'b0;
      r2_px <= '0; r2_gr <= '0; r2_act <= 1'b0; r2_vis <= 1'b0;
      r2_hs <= SYNC_IDLE; r2_vs <= SYNC_IDLE; r2_hit <= 1'b0; r2_phase <= 1'b0;
      r2_run <= 1'b0;
      r3_px <= '0; r3_act <= 1'b0; r3_vis <= 1'b0; r3_attr <= '0;
      r3_hs <= SYNC_IDLE; r3_vs <= SYNC_IDLE; r3_hit <= 1'b0; r3_phase <= 1'b0;
    end else begin
      r_tram_addr <= w_addr;
      r1_px    <= x[2:0];
      r1_gr    <= w_gr;
      r1_act   <= active_in;
      r1_vis   <= w_vis;
      r1_hs    <= hsync_in;
      r1_vs    <= vsync_in;
      r1_hit   <= w_hit;
      r1_phase <= w_phase;
      r1_run   <= 1'b1;

      r2_px    <= r1_px;
      r2_gr    <= r1_gr;
      r2_act   <= r1_act;
      r2_vis   <= r1_vis;
      r2_hs    <= r1_hs;
      r2_vs    <= r1_vs;
      r2_hit   <= r1_hit;
      r2_phase <= r1_phase;
      r2_run   <= r1_run;

      // Text RAM word is valid here; the attribute follows the pixel to the end.
      r3_attr  <= unpack_attr(tram_data);
      r3_px    <= r2_px;
      r3_act   <= r2_act;
      r3_vis   <= r2_vis;
      r3_hs    <= r2_hs;
      r3_vs    <= r2_vs;
      r3_hit   <= r2_hit;
      r3_phase <= r2_phase;
    end
  end

  assign tram_addr = r_tram_addr;
  // Held at zero until a real text RAM word has come back after reset.
  assign font_addr = r2_run ? {tram_data[CHAR_LSB +: 8], r2_gr} : 12'd0;

  // Final pixel select
  logic       w_bit;
  logic       w_on;
  logic [3:0] w_index;

  assign w_bit   = font_data[3'd7 - r3_px];
  assign w_on    = (w_bit && !(r3_attr.blink && r3_phase)) || (r3_hit && !r3_phase);
  assign w_index = pal_index(w_on, r3_attr);

  logic [3:0] r_fg;
  logic [3:0] r_bg;
  logic       r_hs_out;
  logic       r_vs_out;
  logic       r_act_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fg      <= '0;
      r_bg      <= '0;
      r_hs_out  <= SYNC_IDLE;
      r_vs_out  <= SYNC_IDLE;
      r_act_out <= 1'b0;
    end else begin
      r_fg      <= r3_vis ? w_index : 4'd0;
      r_bg      <= r3_vis ? w_index : 4'd0;
      r_hs_out  <= r3_hs;
      r_vs_out  <= r3_vs;
      r_act_out <= r3_act;
    end
  end

  assign fg         = r_fg;
  assign bg         = r_bg;
  assign hsync_out  = r_hs_out;
  assign vsync_out  = r_vs_out;
  assign active_out = r_act_out;

endmodule
